id_ex_register: RTL and testbench

ID/EX pipeline register for the five-stage CPU. It captures the decode-stage control bundles, already bubble-gated in ID, together with operand data, immediate, function bits and register addresses, and presents them to the EX stage one cycle later. It holds its contents under a global pipeline stall. It inserts a bubble on a flush, and a flush that arrives during a stall is remembered and applied afterwards. A saturating counter reports how many bubbles have entered EX.

---
 rtl/id_ex_register.sv | 103 ++++++++++
 tb/tb_id_ex_register.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: captures decode-stage control, operands and addresses for EX,
// with stall hold, deferred flush and a saturating count of bubbles entering EX.
module id_ex_register #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [1:0]        EX_signal_i,
    input  logic [2:0]        MEM_signal_i,
    input  logic [1:0]        WB_signal_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] RS1data_i,
    input  logic [DATA_W-1:0] RS2data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [9:0]        funct_i,
    input  logic [4:0]        RS1addr_i,
    input  logic [4:0]        RS2addr_i,
    input  logic [4:0]        RDaddr_i,
    output logic [1:0]        EX_signal_o,
    output logic [2:0]        MEM_signal_o,
    output logic [1:0]        WB_signal_o,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] RS1data_o,
    output logic [DATA_W-1:0] RS2data_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [9:0]        funct_o,
    output logic [4:0]        RS1addr_o,
    output logic [4:0]        RS2addr_o,
    output logic [4:0]        RDaddr_o,
    output logic              valid_o,
    output logic              flush_pending_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    logic             take_flush;
    logic             upstream_bubble;
    logic             count_bubble;
    logic             cnt_saturated;
    logic [CNT_W-1:0] cnt_next;

    // A flush deferred by an earlier stall is honoured at the first unstalled edge.
    assign take_flush      = !stall_i && (flush_i || flush_pending_o);
    assign upstream_bubble = ({EX_signal_i, MEM_signal_i, WB_signal_i} == 7'd0);
    assign count_bubble    = !stall_i && (take_flush || upstream_bubble);
    assign cnt_saturated   = (bubble_cnt_o == {CNT_W{1'b1}});

    always_comb begin
        cnt_next = bubble_cnt_o;
        if (count_bubble && !cnt_saturated) begin
            cnt_next = bubble_cnt_o + CNT_W'(1);
        end
    end

    // Pending-flush bookkeeping and bubble counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flush_pending_o <= 1'b0;
            bubble_cnt_o    <= '0;
        end else begin
            if (stall_i) begin
                flush_pending_o <= flush_pending_o | flush_i;
            end else begin
                flush_pending_o <= 1'b0;
            end
            bubble_cnt_o <= cnt_next;
        end
    end

    // Payload and valid: hold under stall, zero on flush, otherwise load as presented.
    always_ff @(posedge clk_i) begin
        if (rst_i || take_flush) begin
            EX_signal_o  <= '0;
            MEM_signal_o <= '0;
            WB_signal_o  <= '0;
            pc_o         <= '0;
            RS1data_o    <= '0;
            RS2data_o    <= '0;
            imm_o        <= '0;
            funct_o      <= '0;
            RS1addr_o    <= '0;
            RS2addr_o    <= '0;
            RDaddr_o     <= '0;
            valid_o      <= 1'b0;
        end else if (!stall_i) begin
            EX_signal_o  <= EX_signal_i;
            MEM_signal_o <= MEM_signal_i;
            WB_signal_o  <= WB_signal_i;
            pc_o         <= pc_i;
            RS1data_o    <= RS1data_i;
            RS2data_o    <= RS2data_i;
            imm_o        <= imm_i;
            funct_o      <= funct_i;
            RS1addr_o    <= RS1addr_i;
            RS2addr_o    <= RS2addr_i;
            RDaddr_o     <= RDaddr_i;
            valid_o      <= !upstream_bubble;
        end
    end

endmodule

// File: tb/tb_id_ex_register.sv
// Bench for id_ex_register: directed test-plan steps followed by random traffic,
// all checked against a behavioural model of the pipeline register.
module tb_id_ex_register;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              stall;
    logic              flush;
    logic [1:0]        ex;
    logic [2:0]        mem;
    logic [1:0]        wb;
    logic [DATA_W-1:0] pc, rs1d, rs2d, imm;
    logic [9:0]        funct;
    logic [4:0]        rs1a, rs2a, rda;

    logic [1:0]        exOut;
    logic [2:0]        memOut;
    logic [1:0]        wbOut;
    logic [DATA_W-1:0] pcOut, rs1dOut, rs2dOut, immOut;
    logic [9:0]        functOut;
    logic [4:0]        rs1aOut, rs2aOut, rdaOut;
    logic              validOut;
    logic              pendOut;
    logic [CNT_W-1:0]  cntOut;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [1:0]        ex;
        logic [2:0]        mem;
        logic [1:0]        wb;
        logic [DATA_W-1:0] pc, rs1d, rs2d, imm;
        logic [9:0]        funct;
        logic [4:0]        rs1a, rs2a, rda;
        logic              valid;
    } stage_t;

    stage_t mEx;
    logic   mPending;
    int     mBubbles;

    id_ex_register #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .EX_signal_i(ex), .MEM_signal_i(mem), .WB_signal_i(wb),
        .pc_i(pc), .RS1data_i(rs1d), .RS2data_i(rs2d), .imm_i(imm), .funct_i(funct),
        .RS1addr_i(rs1a), .RS2addr_i(rs2a), .RDaddr_i(rda),
        .EX_signal_o(exOut), .MEM_signal_o(memOut), .WB_signal_o(wbOut),
        .pc_o(pcOut), .RS1data_o(rs1dOut), .RS2data_o(rs2dOut), .imm_o(immOut),
        .funct_o(functOut), .RS1addr_o(rs1aOut), .RS2addr_o(rs2aOut), .RDaddr_o(rdaOut),
        .valid_o(validOut), .flush_pending_o(pendOut), .bubble_cnt_o(cntOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stage_t emptyStage();
        stage_t s;
        s.ex = '0; s.mem = '0; s.wb = '0;
        s.pc = '0; s.rs1d = '0; s.rs2d = '0; s.imm = '0; s.funct = '0;
        s.rs1a = '0; s.rs2a = '0; s.rda = '0; s.valid = 1'b0;
        return s;
    endfunction

    task automatic compare(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Model: what EX should hold after this edge, from the priority rules.
    task automatic applyStimulus();
        if (rst) begin
            mEx      = emptyStage();
            mPending = 1'b0;
            mBubbles = 0;
        end else if (stall) begin
            if (flush) mPending = 1'b1;
        end else if (flush || mPending) begin
            mEx      = emptyStage();
            mPending = 1'b0;
            mBubbles = mBubbles + 1;
        end else begin
            mEx.ex = ex; mEx.mem = mem; mEx.wb = wb;
            mEx.pc = pc; mEx.rs1d = rs1d; mEx.rs2d = rs2d; mEx.imm = imm; mEx.funct = funct;
            mEx.rs1a = rs1a; mEx.rs2a = rs2a; mEx.rda = rda;
            mEx.valid = (ex != 0) || (mem != 0) || (wb != 0);
            if (!mEx.valid) mBubbles = mBubbles + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        int maxCnt;
        maxCnt = (1 << CNT_W) - 1;
        compare("ex",      64'(exOut),    64'(mEx.ex));
        compare("mem",     64'(memOut),   64'(mEx.mem));
        compare("wb",      64'(wbOut),    64'(mEx.wb));
        compare("pc",      64'(pcOut),    64'(mEx.pc));
        compare("rs1data", 64'(rs1dOut),  64'(mEx.rs1d));
        compare("rs2data", 64'(rs2dOut),  64'(mEx.rs2d));
        compare("imm",     64'(immOut),   64'(mEx.imm));
        compare("funct",   64'(functOut), 64'(mEx.funct));
        compare("rs1addr", 64'(rs1aOut),  64'(mEx.rs1a));
        compare("rs2addr", 64'(rs2aOut),  64'(mEx.rs2a));
        compare("rdaddr",  64'(rdaOut),   64'(mEx.rda));
        compare("valid",   64'(validOut), 64'(mEx.valid));
        compare("pending", 64'(pendOut),  64'(mPending));
        compare("bubbles", 64'(cntOut),   64'((mBubbles > maxCnt) ? maxCnt : mBubbles));
    endtask

    task automatic step();
        applyStimulus();
        checkOutput();
    endtask

    task automatic randomPayload();
        pc = $urandom; rs1d = $urandom; rs2d = $urandom; imm = $urandom;
        funct = 10'($urandom); rs1a = 5'($urandom); rs2a = 5'($urandom); rda = 5'($urandom);
        if ($urandom_range(0, 4) == 0) begin
            ex = '0; mem = '0; wb = '0;
        end else begin
            ex = 2'($urandom); mem = 3'($urandom); wb = 2'($urandom);
        end
    endtask

    initial begin
        mEx = emptyStage();
        mPending = 1'b0;
        mBubbles = 0;
        rst = 1'b1; stall = 1'b1; flush = 1'b1;
        ex = 2'b11; mem = 3'b111; wb = 2'b11;
        pc = 32'hdead_beef; rs1d = 32'h1; rs2d = 32'h2; imm = 32'h3;
        funct = 10'h3ff; rs1a = 5'd1; rs2a = 5'd2; rda = 5'd3;

        $display("[TB] reset with non-zero inputs");
        step();
        step();
        compare("reset_valid_const", 64'(validOut), 64'd0);

        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        ex = 2'b10; mem = 3'b010; wb = 2'b11; rda = 5'd7;
        step();
        compare("first_load_valid_const", 64'(validOut), 64'd1);
        compare("first_load_cnt_const", 64'(cntOut), 64'd0);

        $display("[TB] hold under stall");
        pc = 32'h40; rs1d = 32'haaaa; step();
        stall = 1'b1; pc = 32'h44; rs1d = 32'hbbbb; ex = 2'b01;
        step(); step(); step();
        compare("hold_pc_const", 64'(pcOut), 64'h40);
        stall = 1'b0;
        step();
        compare("release_pc_const", 64'(pcOut), 64'h44);

        $display("[TB] flush and deferred flush");
        flush = 1'b1; step();
        compare("flush_cnt_const", 64'(cntOut), 64'd1);
        flush = 1'b0; step();
        stall = 1'b1; flush = 1'b1; pc = 32'h80; step();
        compare("deferred_pending_const", 64'(pendOut), 64'd1);
        stall = 1'b0; flush = 1'b0; step();
        compare("deferred_cnt_const", 64'(cntOut), 64'd2);
        stall = 1'b1; flush = 1'b1; step();
        stall = 1'b0; step();

        $display("[TB] upstream bubble");
        flush = 1'b0; ex = '0; mem = '0; wb = '0; rs1d = 32'h1234; step();
        compare("bubble_rs1_const", 64'(rs1dOut), 64'h1234);

        $display("[TB] saturation");
        for (int i = 0; i < 17; i++) step();
        compare("saturate_const", 64'(cntOut), 64'hf);

        $display("[TB] reset discards pending flush");
        ex = 2'b01; stall = 1'b1; flush = 1'b1; step();
        rst = 1'b1; stall = 1'b0; flush = 1'b0; step();
        rst = 1'b0; step();
        compare("post_reset_valid_const", 64'(validOut), 64'd1);
        compare("post_reset_cnt_const", 64'(cntOut), 64'd0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            randomPayload();
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 4) == 0);
            rst   = ($urandom_range(0, 80) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
